memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 34 +++
 rtl/memory_stage_req_latch.sv | 30 +++
 rtl/memory_stage.sv | 148 ++++++++++++++
 tb/tb_memory_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared defines and types for the memory stage: data width, zero constant, FSM encodings, latched request bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef MEMORY_STAGE_PKG_SV
`define MEMORY_STAGE_PKG_SV

`define INST_SIZE       32
`define INST_SIZE_ZEROS 32'h0000_0000
`define MS_STATE_IDLE   1'b0
`define MS_STATE_WAIT   1'b1

package memory_stage_pkg;

    // Wide enough for RESP_WAIT_MAX up to 255
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE = `MS_STATE_IDLE,
        ST_WAIT = `MS_STATE_WAIT
    } state_e;

    // Everything needed to replay the request and finish write-back once the ack arrives
    typedef struct packed {
        logic [`INST_SIZE-1:0] addr;
        logic [`INST_SIZE-1:0] wdata;
        logic                  we;
        logic [4:0]            rd;
        logic                  me_we;
        logic                  mem_reg;
    } req_t;

endpackage

`endif

// File: rtl/memory_stage_req_latch.sv
// MemReqLatch: holds the outstanding data-memory request and its write-back bundle.
// Latency: 1 cycle from load_i to q_o; clr_i wins over load_i.
// Backpressure: none; the parent decides when to load and clear.
module MemReqLatch
    import memory_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    input  req_t d_i,
    output req_t q_o
);

    req_t bundle_q;

    // Capture the request when it stalls; drop it on completion or timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bundle_q <= '0;
        end else if (clr_i) begin
            bundle_q <= '0;
        end else if (load_i) begin
            bundle_q <= d_i;
        end
    end

    assign q_o = bundle_q;

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues data-memory requests, stalls upstream until ack, registers MEM/WB.
// Latency: 1 cycle to WB for ALU ops and zero-wait accesses; 1 cycle after ack otherwise.
// Backpressure: STALL_MEM freezes IF/ID/EX while a request is outstanding; MEM_ALIGN_CHECK_EN enables misalignment rejection.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int RESP_WAIT_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [`INST_SIZE-1:0] ALU_OUT,
    input  logic [4:0]            RD,
    input  logic [`INST_SIZE-1:0] WD_ME,
    input  logic                  MEM_WE_ME,
    input  logic                  ME_WE,
    input  logic                  MEM_REG_ME,
    output logic                  DMEM_REQ,
    output logic                  DMEM_WE,
    output logic [`INST_SIZE-1:0] DMEM_ADDR,
    output logic [`INST_SIZE-1:0] DMEM_WDATA,
    input  logic [`INST_SIZE-1:0] DMEM_RDATA,
    input  logic                  DMEM_ACK,
    output logic [`INST_SIZE-1:0] BP_MEM,
    output logic                  STALL_MEM,
    output logic [`INST_SIZE-1:0] WB_DATA,
    output logic [4:0]            WB_RD,
    output logic                  WB_WE,
    output logic                  MEM_ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESP_WAIT_MAX - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [`INST_SIZE-1:0] wb_data_q, wb_data_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic                  wb_we_q, wb_we_d;
    req_t                  lat_q, lat_d;
    logic                  lat_load, lat_clr;

    logic mem_op, misaligned, in_wait, idle_issue, req_raw, timeout;

    assign mem_op = MEM_WE_ME | MEM_REG_ME;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op & (ALU_OUT[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign in_wait    = (state_q == ST_WAIT);
    assign idle_issue = !in_wait & mem_op & !misaligned;
    assign req_raw    = in_wait | idle_issue;
    // Ack takes priority over timeout on the last allowed cycle
    assign timeout    = in_wait & !DMEM_ACK & (cnt_q == CNT_LAST);

    assign lat_d    = '{addr: ALU_OUT, wdata: WD_ME, we: MEM_WE_ME, rd: RD,
                        me_we: ME_WE, mem_reg: MEM_REG_ME};
    assign lat_load = idle_issue & !DMEM_ACK;
    assign lat_clr  = in_wait & (DMEM_ACK | timeout);

    MemReqLatch u_req_latch (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (lat_clr),
        .load_i (lat_load),
        .d_i    (lat_d),
        .q_o    (lat_q)
    );

    // Request and stall are combinational so a zero-wait ack never stalls; reset forces them low at once
    assign DMEM_REQ   = rst & req_raw;
    assign DMEM_WE    = rst & (in_wait ? lat_q.we : (idle_issue & MEM_WE_ME));
    assign DMEM_ADDR  = rst ? (in_wait ? lat_q.addr  : ALU_OUT) : `INST_SIZE_ZEROS;
    assign DMEM_WDATA = rst ? (in_wait ? lat_q.wdata : WD_ME)   : `INST_SIZE_ZEROS;
    assign STALL_MEM  = rst & req_raw & !DMEM_ACK & !timeout;
    assign MEM_ERR    = rst & (timeout | (!in_wait & misaligned));
    assign BP_MEM     = ALU_OUT;

    assign WB_DATA = wb_data_q;
    assign WB_RD   = wb_rd_q;
    assign WB_WE   = wb_we_q;

    // Next-state and MEM/WB write-back selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        wb_we_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (misaligned) begin
                    wb_we_d = 1'b0;
                end else if (mem_op) begin
                    if (DMEM_ACK) begin
                        wb_data_d = MEM_REG_ME ? DMEM_RDATA : ALU_OUT;
                        wb_rd_d   = RD;
                        wb_we_d   = MEM_REG_ME ? (ME_WE & (RD != 5'd0)) : ME_WE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end else begin
                    wb_data_d = ALU_OUT;
                    wb_rd_d   = RD;
                    wb_we_d   = ME_WE;
                end
            end
            ST_WAIT: begin
                if (DMEM_ACK) begin
                    wb_data_d = lat_q.mem_reg ? DMEM_RDATA : lat_q.addr;
                    wb_rd_d   = lat_q.rd;
                    wb_we_d   = lat_q.mem_reg ? (lat_q.me_we & (lat_q.rd != 5'd0)) : lat_q.me_we;
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                end else if (timeout) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, wait counter and MEM/WB register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wb_data_q <= `INST_SIZE_ZEROS;
            wb_rd_q   <= 5'd0;
            wb_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, zero-wait and stalled loads, store, timeout, reset abort, alignment.
// Latency: expected write-backs are queued at issue and retired when WB_WE rises.
// Backpressure: stall cycles checked cycle by cycle against fixed ack timing.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ALU_OUT = '0;
    logic [4:0]  RD = '0;
    logic [31:0] WD_ME = '0;
    logic        MEM_WE_ME = 1'b0;
    logic        ME_WE = 1'b0;
    logic        MEM_REG_ME = 1'b0;
    logic        DMEM_REQ, DMEM_WE;
    logic [31:0] DMEM_ADDR, DMEM_WDATA;
    logic [31:0] DMEM_RDATA = '0;
    logic        DMEM_ACK = 1'b0;
    logic [31:0] BP_MEM;
    logic        STALL_MEM;
    logic [31:0] WB_DATA;
    logic [4:0]  WB_RD;
    logic        WB_WE;
    logic        MEM_ERR;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_exp_t;

    wb_exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    memory_stage #(.RESP_WAIT_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALU_OUT    (ALU_OUT),
        .RD         (RD),
        .WD_ME      (WD_ME),
        .MEM_WE_ME  (MEM_WE_ME),
        .ME_WE      (ME_WE),
        .MEM_REG_ME (MEM_REG_ME),
        .DMEM_REQ   (DMEM_REQ),
        .DMEM_WE    (DMEM_WE),
        .DMEM_ADDR  (DMEM_ADDR),
        .DMEM_WDATA (DMEM_WDATA),
        .DMEM_RDATA (DMEM_RDATA),
        .DMEM_ACK   (DMEM_ACK),
        .BP_MEM     (BP_MEM),
        .STALL_MEM  (STALL_MEM),
        .WB_DATA    (WB_DATA),
        .WB_RD      (WB_RD),
        .WB_WE      (WB_WE),
        .MEM_ERR    (MEM_ERR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_wb(input logic [31:0] data, input logic [4:0] rd);
        wb_exp_t e;
        e.data = data;
        e.rd   = rd;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ALU_OUT    = '0;
        RD         = '0;
        WD_ME      = '0;
        MEM_WE_ME  = 1'b0;
        ME_WE      = 1'b0;
        MEM_REG_ME = 1'b0;
        DMEM_ACK   = 1'b0;
        DMEM_RDATA = '0;
    endtask

    // Scoreboard retire: every write-back must match the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (rst === 1'b1 && WB_WE === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected_wb: observed data %h rd %0d expected no write-back", WB_DATA, WB_RD);
            end
            if (sb.size() != 0) begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("sb_wb_data", WB_DATA, e.data);
                chk("sb_wb_rd", 32'(WB_RD), 32'(e.rd));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with a memory op on the inputs
        #2;
        ALU_OUT = 32'h40; MEM_REG_ME = 1'b1; ME_WE = 1'b1;
        #1;
        chk("rst_req", 32'(DMEM_REQ), 0);
        chk("rst_stall", 32'(STALL_MEM), 0);
        chk("rst_err", 32'(MEM_ERR), 0);
        chk("rst_wb_we", 32'(WB_WE), 0);
        chk("rst_wb_data", WB_DATA, 0);
        idle_in();
        cyc(); cyc();
        #2 rst = 1'b1;

        // ALU op: one-cycle write-back, no stall
        cyc();
        ALU_OUT = 32'h10; RD = 5'd5; ME_WE = 1'b1;
        #2;
        chk("alu_stall", 32'(STALL_MEM), 0);
        chk("alu_req", 32'(DMEM_REQ), 0);
        chk("alu_bp", BP_MEM, 32'h10);
        push_wb(32'h10, 5'd5);
        cyc();
        idle_in();
        chk("alu_wb_we", 32'(WB_WE), 1);

        // Zero-wait load
        cyc();
        ALU_OUT = 32'h100; RD = 5'd7; MEM_REG_ME = 1'b1; ME_WE = 1'b1;
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'hDEADBEEF;
        #2;
        chk("zw_req", 32'(DMEM_REQ), 1);
        chk("zw_we", 32'(DMEM_WE), 0);
        chk("zw_addr", DMEM_ADDR, 32'h100);
        chk("zw_stall", 32'(STALL_MEM), 0);
        push_wb(32'hDEADBEEF, 5'd7);
        cyc();
        idle_in();
        chk("zw_wb_we", 32'(WB_WE), 1);

        // Load with three stalled cycles; inputs change while waiting
        cyc();
        ALU_OUT = 32'h200; RD = 5'd9; MEM_REG_ME = 1'b1; ME_WE = 1'b1;
        #2;
        chk("w3_stall0", 32'(STALL_MEM), 1);
        chk("w3_req0", 32'(DMEM_REQ), 1);
        for (int i = 1; i <= 2; i++) begin
            cyc();
            ALU_OUT = 32'hFFFF_FFF0; RD = 5'd3; MEM_REG_ME = 1'b0; ME_WE = 1'b1;
            chk("w3_bubble", 32'(WB_WE), 0);
            #2;
            chk("w3_stall", 32'(STALL_MEM), 1);
            chk("w3_addr_held", DMEM_ADDR, 32'h200);
        end
        cyc();
        idle_in();
        chk("w3_bubble_last", 32'(WB_WE), 0);
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'h12345678;
        #2;
        chk("w3_stall_ack", 32'(STALL_MEM), 0);
        push_wb(32'h12345678, 5'd9);
        cyc();
        idle_in();
        chk("w3_wb_we", 32'(WB_WE), 1);

        // Store, ack one cycle later; request held stable
        cyc();
        ALU_OUT = 32'h20; WD_ME = 32'h55; MEM_WE_ME = 1'b1;
        #2;
        chk("st_we", 32'(DMEM_WE), 1);
        chk("st_wdata", DMEM_WDATA, 32'h55);
        chk("st_stall", 32'(STALL_MEM), 1);
        cyc();
        ALU_OUT = 32'h99; WD_ME = 32'hAA; MEM_WE_ME = 1'b0; DMEM_ACK = 1'b1;
        #2;
        chk("st_we_held", 32'(DMEM_WE), 1);
        chk("st_wdata_held", DMEM_WDATA, 32'h55);
        chk("st_addr_held", DMEM_ADDR, 32'h20);
        chk("st_stall_ack", 32'(STALL_MEM), 0);
        cyc();
        idle_in();
        chk("st_wb_we", 32'(WB_WE), 0);

        // Timeout: error on the fourth wait cycle
        cyc();
        ALU_OUT = 32'h300; RD = 5'd4; MEM_REG_ME = 1'b1; ME_WE = 1'b1;
        #2;
        chk("to_err_issue", 32'(MEM_ERR), 0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            idle_in();
            #2;
            chk("to_err", 32'(MEM_ERR), (i == 4) ? 32'd1 : 32'd0);
            chk("to_stall", 32'(STALL_MEM), (i == 4) ? 32'd0 : 32'd1);
        end
        cyc();
        chk("to_req_after", 32'(DMEM_REQ), 0);
        chk("to_err_after", 32'(MEM_ERR), 0);
        chk("to_wb_we", 32'(WB_WE), 0);

        // Stray ack with no request outstanding; leave a nonzero WB_DATA behind
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'h0BAD; ALU_OUT = 32'h77; RD = 5'd8;
        #2;
        chk("stray_req", 32'(DMEM_REQ), 0);
        chk("stray_stall", 32'(STALL_MEM), 0);
        cyc();
        idle_in();
        chk("stray_wb_data", WB_DATA, 32'h77);

        // Reset while waiting: everything drops at once, late ack ignored
        ALU_OUT = 32'h400; RD = 5'd6; MEM_REG_ME = 1'b1; ME_WE = 1'b1;
        cyc();
        idle_in();
        #1 rst = 1'b0;
        #1;
        chk("rw_req", 32'(DMEM_REQ), 0);
        chk("rw_addr", DMEM_ADDR, 0);
        chk("rw_stall", 32'(STALL_MEM), 0);
        chk("rw_wb_data", WB_DATA, 0);
        chk("rw_wb_rd", 32'(WB_RD), 0);
        chk("rw_wb_we", 32'(WB_WE), 0);
        cyc(); cyc();
        #2;
        rst = 1'b1; DMEM_ACK = 1'b1; DMEM_RDATA = 32'hFACE;
        #1;
        chk("rw_late_stall", 32'(STALL_MEM), 0);
        cyc();
        idle_in();
        chk("rw_late_wb_we", 32'(WB_WE), 0);
        chk("rw_late_req", 32'(DMEM_REQ), 0);

        // Misaligned load
        cyc();
        ALU_OUT = 32'h102; RD = 5'd2; MEM_REG_ME = 1'b1; ME_WE = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
        #2;
        chk("al_err", 32'(MEM_ERR), 1);
        chk("al_req", 32'(DMEM_REQ), 0);
        chk("al_stall", 32'(STALL_MEM), 0);
        cyc();
        idle_in();
        chk("al_wb_we", 32'(WB_WE), 0);
        #2;
        chk("al_idle_req", 32'(DMEM_REQ), 0);
`else
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'hCAFE0102;
        #2;
        chk("al_err", 32'(MEM_ERR), 0);
        chk("al_req", 32'(DMEM_REQ), 1);
        chk("al_addr", DMEM_ADDR, 32'h102);
        push_wb(32'hCAFE0102, 5'd2);
        cyc();
        idle_in();
        chk("al_wb_we", 32'(WB_WE), 1);
`endif

        // Load to r0 completes but does not write back
        cyc();
        ALU_OUT = 32'h500; RD = 5'd0; MEM_REG_ME = 1'b1; ME_WE = 1'b1;
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'h11112222;
        #2;
        chk("r0_req", 32'(DMEM_REQ), 1);
        cyc();
        idle_in();
        chk("r0_wb_we", 32'(WB_WE), 0);

        cyc();
        chk("sb_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
